// File: rtl/dcache.sv
// Direct-mapped write-through, no-write-allocate data cache.
// Define DCACHE_PERF_EN to add saturating hit/miss/write counters.
module dcache #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 17,
    parameter int LINES          = 64,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  MemReadM,
    input  logic                  MemWriteM,
    input  logic [2:0]            SizeCtr,
    input  logic [ADDR_WIDTH-1:0] ALUResultM,
    input  logic [DATA_WIDTH-1:0] WriteDataM,
    output logic [DATA_WIDTH-1:0] ReadData,
    output logic                  Stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_be,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef DCACHE_PERF_EN
    ,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count,
    output logic [31:0]           wr_count
`endif
);
    localparam int WB = $clog2(WORDS_PER_LINE);
    localparam int IB = $clog2(LINES);
    localparam int TB = ADDR_WIDTH - IB - WB - 2;
    localparam int LB = TB + IB;

    typedef enum logic [1:0] {IDLE, REFILL, WRITE} stateT;
    stateT state, stateNext;

    logic [DATA_WIDTH-1:0] dataArr [LINES*WORDS_PER_LINE];
    logic [TB-1:0]         tagArr  [LINES];
    logic [LINES-1:0]      validQ;

    logic [1:0]            offs;
    logic [WB-1:0]         wordSel;
    logic [IB-1:0]         idx;
    logic [TB-1:0]         tag;
    logic [LB-1:0]         lineQ;
    logic [WB-1:0]         beatQ;
    logic [ADDR_WIDTH-1:0] wAddrQ;
    logic [DATA_WIDTH-1:0] wDataQ;
    logic [3:0]            wBeQ;
    logic                  doneQ;

    logic                  hit, storeGo, missGo, lastBeat, beatTake;
    logic [1:0]            laneOff;
    logic [3:0]            be;
    logic [DATA_WIDTH-1:0] beMask, laneData, curWord, merged;
    logic [DATA_WIDTH-1:0] shifted, loadVal;

    assign offs     = ALUResultM[1:0];
    assign wordSel  = ALUResultM[WB+1:2];
    assign idx      = ALUResultM[IB+WB+1:WB+2];
    assign tag      = ALUResultM[ADDR_WIDTH-1:IB+WB+2];

    assign hit      = validQ[idx] && (tagArr[idx] == tag);
    assign curWord  = dataArr[{idx, wordSel}];
    // doneQ masks the held store for the one cycle after its write beat
    assign storeGo  = MemWriteM && !doneQ;
    assign missGo   = MemReadM && !MemWriteM && !hit;
    assign lastBeat = beatQ == WB'(WORDS_PER_LINE - 1);
    assign beatTake = (state == REFILL) && mem_ready;

    always_comb begin
        laneOff = 2'b00;
        be      = 4'b1111;
        unique case (SizeCtr[1:0])
            2'b00: begin
                laneOff = offs;
                be      = 4'b0001 << offs;
            end
            2'b01: begin
                laneOff = {offs[1], 1'b0};
                be      = 4'b0011 << {offs[1], 1'b0};
            end
            default: ;
        endcase
    end

    always_comb begin
        beMask = '0;
        for (int i = 0; i < 4; i++) begin
            beMask[8*i +: 8] = {8{be[i]}};
        end
    end

    assign laneData = (WriteDataM << {laneOff, 3'b000}) & beMask;
    assign merged   = (curWord & ~beMask) | laneData;

    always_comb begin
        shifted = curWord >> {laneOff, 3'b000};
        unique case (SizeCtr[1:0])
            2'b00: loadVal = {{(DATA_WIDTH-8){!SizeCtr[2] & shifted[7]}},
                              shifted[7:0]};
            2'b01: loadVal = {{(DATA_WIDTH-16){!SizeCtr[2] & shifted[15]}},
                              shifted[15:0]};
            default: loadVal = shifted;
        endcase
        ReadData = (MemReadM && hit) ? loadVal : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: begin
                if (storeGo)     stateNext = WRITE;
                else if (missGo) stateNext = REFILL;
            end
            REFILL: if (mem_ready && lastBeat) stateNext = IDLE;
            WRITE:  if (mem_ready) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        Stall     = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        unique case (state)
            IDLE: Stall = storeGo || missGo;
            REFILL: begin
                Stall    = 1'b1;
                mem_req  = 1'b1;
                mem_addr = {lineQ, beatQ, 2'b00};
            end
            WRITE: begin
                Stall     = 1'b1;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = wAddrQ;
                mem_wdata = wDataQ;
                mem_be    = wBeQ;
            end
            default: ;
        endcase
        if (!rst) Stall = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            validQ <= '0;
            lineQ  <= '0;
            beatQ  <= '0;
            wAddrQ <= '0;
            wDataQ <= '0;
            wBeQ   <= '0;
            doneQ  <= 1'b0;
        end else begin
            doneQ <= (state != IDLE) && (stateNext == IDLE);
            if (state == IDLE && storeGo) begin
                wAddrQ <= {ALUResultM[ADDR_WIDTH-1:2], 2'b00};
                wDataQ <= laneData;
                wBeQ   <= be;
            end
            // the line is invalid until every beat has landed
            if (state == IDLE && !storeGo && missGo) begin
                lineQ       <= ALUResultM[ADDR_WIDTH-1:WB+2];
                beatQ       <= '0;
                validQ[idx] <= 1'b0;
            end
            if (beatTake) begin
                beatQ <= beatQ + WB'(1);
                if (lastBeat) validQ[lineQ[IB-1:0]] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (beatTake) begin
            dataArr[{lineQ[IB-1:0], beatQ}] <= mem_rdata;
            if (lastBeat) tagArr[lineQ[IB-1:0]] <= lineQ[LB-1:IB];
        end
        if (state == IDLE && storeGo && hit) begin
            dataArr[{idx, wordSel}] <= merged;
        end
    end

`ifdef DCACHE_PERF_EN
    logic hitEv, missEv, wrEv;
    assign hitEv  = (state == IDLE) && MemReadM && !MemWriteM && hit && !doneQ;
    assign missEv = beatTake && lastBeat;
    assign wrEv   = (state == WRITE) && mem_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_count  <= '0;
            miss_count <= '0;
            wr_count   <= '0;
        end else begin
            if (hitEv && hit_count != '1)   hit_count  <= hit_count + 32'd1;
            if (missEv && miss_count != '1) miss_count <= miss_count + 32'd1;
            if (wrEv && wr_count != '1)     wr_count   <= wr_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_dcache.sv
// Bench for dcache: directed vector table, reset-during-refill sequence,
// then random loads/stores against a line-map and memory reference model.
`timescale 1ns/1ps
module tb_dcache;
    logic        clk = 1'b0;
    logic        rst;
    logic        MemReadM, MemWriteM;
    logic [2:0]  SizeCtr;
    logic [16:0] ALUResultM;
    logic [31:0] WriteDataM, ReadData;
    logic        Stall, mem_req, mem_we, mem_ready;
    logic [16:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    dcache dut (
        .clk(clk), .rst(rst), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
        .SizeCtr(SizeCtr), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .ReadData(ReadData), .Stall(Stall), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [16:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } beatT;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [2:0]  sz;
        logic [16:0] addr;
        logic [31:0] wd;
        logic [31:0] expData;
        logic [3:0]  expBe;
        int          expRd;
        int          expWr;
        int          expStall;
    } vecT;

    beatT        beats[$];
    logic [31:0] memArr [32768];
    logic [31:0] refMem [32768];
    int          cachedLine [64];
    int          total = 0;
    int          bad = 0;
    logic        pendQ = 1'b0;
    beatT        prevB;

    assign mem_rdata = memArr[mem_addr[16:2]];

    always @(negedge clk) begin
        if (rst && mem_req && mem_ready) begin
            beats.push_back('{mem_we, mem_addr, mem_wdata, mem_be});
            if (mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_be[b]) memArr[mem_addr[16:2]][8*b +: 8] = mem_wdata[8*b +: 8];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            pendQ = 1'b0;
        end else begin
            if (pendQ) begin
                total++;
                if (mem_req !== 1'b1 || mem_we !== prevB.we || mem_addr !== prevB.addr ||
                    mem_wdata !== prevB.wdata || mem_be !== prevB.be) begin
                    bad++;
                    $display("FAIL hold: payload changed before ready (addr %h was %h)",
                             mem_addr, prevB.addr);
                end
            end
            pendQ = mem_req && !mem_ready;
            prevB = '{mem_we, mem_addr, mem_wdata, mem_be};
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic vecT mk(bit rd, bit wr, logic [2:0] sz, logic [16:0] a,
                               logic [31:0] wd, logic [31:0] ed, logic [3:0] eb,
                               int er, int ew, int es);
        vecT v;
        v.rd = rd; v.wr = wr; v.sz = sz; v.addr = a; v.wd = wd;
        v.expData = ed; v.expBe = eb; v.expRd = er; v.expWr = ew; v.expStall = es;
        return v;
    endfunction

    function automatic logic [3:0] beOf(logic [2:0] sz, logic [16:0] a);
        int off = int'(a) % 4;
        if (sz[1:0] == 2'b00) return 4'(1 << off);
        if (sz[1:0] == 2'b01) return 4'(3 << (off / 2 * 2));
        return 4'hF;
    endfunction

    function automatic logic [31:0] laneOf(logic [2:0] sz, logic [16:0] a, logic [31:0] wd);
        int off = int'(a) % 4;
        if (sz[1:0] == 2'b00) return (wd & 32'hFF) << (8 * off);
        if (sz[1:0] == 2'b01) return (wd & 32'hFFFF) << (16 * (off / 2));
        return wd;
    endfunction

    function automatic logic [31:0] maskOf(logic [3:0] b);
        logic [31:0] m = '0;
        for (int i = 0; i < 4; i++) if (b[i]) m = m | (32'hFF << (8 * i));
        return m;
    endfunction

    function automatic logic [31:0] loadExp(logic [31:0] w, logic [2:0] sz, logic [16:0] a);
        int off = int'(a) % 4;
        logic [31:0] v;
        if (sz[1:0] == 2'b00) begin
            v = (w >> (8 * off)) & 32'hFF;
            if (!sz[2] && v >= 32'h80) v = v - 32'h100;
        end else if (sz[1:0] == 2'b01) begin
            v = (w >> (16 * (off / 2))) & 32'hFFFF;
            if (!sz[2] && v >= 32'h8000) v = v - 32'h10000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    task automatic runOp(input vecT v, input bit randReady, output logic [31:0] rdOut,
                         output int stallCyc, output bit timedOut);
        beats.delete();
        MemReadM   = v.rd;
        MemWriteM  = v.wr;
        SizeCtr    = v.sz;
        ALUResultM = v.addr;
        WriteDataM = v.wd;
        stallCyc   = 0;
        timedOut   = 1'b0;
        rdOut      = '0;
        forever begin
            mem_ready = randReady ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(negedge clk);
            if (!Stall) begin
                rdOut = ReadData;
                break;
            end
            stallCyc++;
            if (stallCyc > 200) begin
                timedOut = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        MemReadM  = 1'b0;
        MemWriteM = 1'b0;
    endtask

    task automatic runAndCheck(input vecT v, input bit randReady, input bit chkStall,
                               input string tg);
        logic [31:0] got;
        int          stallCyc, rdN, wrN, k;
        bit          to;
        logic [31:0] m;
        runOp(v, randReady, got, stallCyc, to);
        if (to) begin
            total++;
            bad++;
            $display("FAIL %s timeout: Stall still 1 after 200 cycles, required 0", tg);
            return;
        end
        rdN = 0;
        wrN = 0;
        k   = 0;
        foreach (beats[i]) begin
            if (beats[i].we) begin
                wrN++;
            end else begin
                check({tg, " rdaddr"}, 32'(beats[i].addr),
                      32'({v.addr[16:4], 4'b0000}) + 32'(4 * k));
                k++;
            end
        end
        if (v.rd && !v.wr) check({tg, " data"}, got, v.expData);
        check({tg, " rdbeats"}, 32'(rdN + k), 32'(v.expRd));
        check({tg, " wrbeats"}, 32'(wrN), 32'(v.expWr));
        if (chkStall) check({tg, " stall"}, 32'(stallCyc), 32'(v.expStall));
        if (v.wr && wrN == 1 && beats.size() == 1) begin
            m = maskOf(v.expBe);
            check({tg, " be"}, 32'(beats[0].be), 32'(v.expBe));
            check({tg, " wdata"}, beats[0].wdata & m, v.expData & m);
            check({tg, " waddr"}, 32'(beats[0].addr), 32'({v.addr[16:2], 2'b00}));
        end
        if (v.wr) begin
            for (int b = 0; b < 4; b++) begin
                if (v.expBe[b]) refMem[v.addr[16:2]][8*b +: 8] = v.expData[8*b +: 8];
            end
        end
    endtask

    vecT tbl[$];

    initial begin
        vecT v;
        int  ln, ix, sel;
        bit  isSt;

        for (int i = 0; i < 32768; i++) begin
            memArr[i] = 32'(i) * 32'h9E3779B1 + 32'h01234567;
        end
        memArr[32'h40 >> 2]    = 32'h11111111;
        memArr[32'h44 >> 2]    = 32'h22222222;
        memArr[32'h48 >> 2]    = 32'h33333333;
        memArr[32'h4C >> 2]    = 32'h44444444;
        memArr[32'h1FFFC >> 2] = 32'hDEADBEEF;
        memArr[32'h1440 >> 2]  = 32'h0BADCAFE;
        for (int i = 0; i < 32768; i++) refMem[i] = memArr[i];

        rst        = 1'b0;
        MemReadM   = 1'b1;
        MemWriteM  = 1'b0;
        SizeCtr    = 3'b010;
        ALUResultM = 17'h40;
        WriteDataM = 32'h0;
        mem_ready  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst Stall", 32'(Stall), 32'h0);
        check("rst mem_req", 32'(mem_req), 32'h0);
        check("rst mem_we", 32'(mem_we), 32'h0);
        check("rst mem_addr", 32'(mem_addr), 32'h0);
        check("rst mem_wdata", mem_wdata, 32'h0);
        check("rst mem_be", 32'(mem_be), 32'h0);
        check("rst ReadData", ReadData, 32'h0);
        MemReadM = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;

        tbl.push_back(mk(1'b1, 1'b0, 3'b010, 17'h00040, 32'h0, 32'h11111111, 4'h0, 4, 0, 5));
        tbl.push_back(mk(1'b1, 1'b0, 3'b010, 17'h00048, 32'h0, 32'h33333333, 4'h0, 0, 0, 0));
        tbl.push_back(mk(1'b0, 1'b1, 3'b010, 17'h00040, 32'h80FF7F01, 32'h80FF7F01, 4'hF, 0, 1, 2));
        tbl.push_back(mk(1'b1, 1'b0, 3'b000, 17'h00043, 32'h0, 32'hFFFFFF80, 4'h0, 0, 0, 0));
        tbl.push_back(mk(1'b1, 1'b0, 3'b100, 17'h00043, 32'h0, 32'h00000080, 4'h0, 0, 0, 0));
        tbl.push_back(mk(1'b1, 1'b0, 3'b001, 17'h00042, 32'h0, 32'hFFFF80FF, 4'h0, 0, 0, 0));
        tbl.push_back(mk(1'b1, 1'b0, 3'b101, 17'h00042, 32'h0, 32'h000080FF, 4'h0, 0, 0, 0));
        tbl.push_back(mk(1'b1, 1'b0, 3'b001, 17'h00043, 32'h0, 32'hFFFF80FF, 4'h0, 0, 0, 0));
        tbl.push_back(mk(1'b0, 1'b1, 3'b000, 17'h00041, 32'h123456AB, 32'h0000AB00, 4'b0010, 0, 1, 2));
        tbl.push_back(mk(1'b1, 1'b0, 3'b010, 17'h00040, 32'h0, 32'h80FFAB01, 4'h0, 0, 0, 0));
        tbl.push_back(mk(1'b1, 1'b0, 3'b010, 17'h00043, 32'h0, 32'h80FFAB01, 4'h0, 0, 0, 0));
        tbl.push_back(mk(1'b0, 1'b1, 3'b001, 17'h00046, 32'hFFFF8001, 32'h80010000, 4'b1100, 0, 1, 2));
        tbl.push_back(mk(1'b1, 1'b0, 3'b001, 17'h00046, 32'h0, 32'hFFFF8001, 4'h0, 0, 0, 0));
        tbl.push_back(mk(1'b1, 1'b0, 3'b010, 17'h00044, 32'h0, 32'h80012222, 4'h0, 0, 0, 0));
        tbl.push_back(mk(1'b0, 1'b1, 3'b010, 17'h01000, 32'hCAFEF00D, 32'hCAFEF00D, 4'hF, 0, 1, 2));
        tbl.push_back(mk(1'b1, 1'b0, 3'b010, 17'h01000, 32'h0, 32'hCAFEF00D, 4'h0, 4, 0, 5));
        tbl.push_back(mk(1'b1, 1'b0, 3'b010, 17'h00040, 32'h0, 32'h80FFAB01, 4'h0, 0, 0, 0));
        tbl.push_back(mk(1'b1, 1'b0, 3'b100, 17'h0004E, 32'h0, 32'h00000044, 4'h0, 0, 0, 0));
        tbl.push_back(mk(1'b1, 1'b0, 3'b010, 17'h1FFFC, 32'h0, 32'hDEADBEEF, 4'h0, 4, 0, 5));
        tbl.push_back(mk(1'b1, 1'b0, 3'b000, 17'h1FFFF, 32'h0, 32'hFFFFFFDE, 4'h0, 0, 0, 0));
        tbl.push_back(mk(1'b0, 1'b1, 3'b000, 17'h1FFFE, 32'h0000007F, 32'h007F0000, 4'b0100, 0, 1, 2));
        tbl.push_back(mk(1'b1, 1'b0, 3'b001, 17'h1FFFE, 32'h0, 32'hFFFFDE7F, 4'h0, 0, 0, 0));
        tbl.push_back(mk(1'b1, 1'b0, 3'b010, 17'h1FFFC, 32'h0, 32'hDE7FBEEF, 4'h0, 0, 0, 0));
        tbl.push_back(mk(1'b1, 1'b1, 3'b010, 17'h00048, 32'h5555AAAA, 32'h5555AAAA, 4'hF, 0, 1, 2));
        tbl.push_back(mk(1'b1, 1'b0, 3'b010, 17'h00048, 32'h0, 32'h5555AAAA, 4'h0, 0, 0, 0));
        tbl.push_back(mk(1'b1, 1'b0, 3'b010, 17'h01440, 32'h0, 32'h0BADCAFE, 4'h0, 4, 0, 5));
        tbl.push_back(mk(1'b1, 1'b0, 3'b010, 17'h00040, 32'h0, 32'h80FFAB01, 4'h0, 4, 0, 5));

        foreach (tbl[i]) runAndCheck(tbl[i], 1'b0, 1'b1, $sformatf("vec%0d", i));

        // reset lands after two refill beats
        beats.delete();
        MemReadM   = 1'b1;
        MemWriteM  = 1'b0;
        SizeCtr    = 3'b010;
        ALUResultM = 17'h02000;
        mem_ready  = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("midrst beats", 32'(beats.size()), 32'd2);
        check("midrst req before", 32'(mem_req), 32'h1);
        rst = 1'b0;
        #1;
        check("midrst mem_req", 32'(mem_req), 32'h0);
        check("midrst Stall", 32'(Stall), 32'h0);
        check("midrst ReadData", ReadData, 32'h0);
        @(posedge clk);
        #1;
        MemReadM = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        runAndCheck(mk(1'b1, 1'b0, 3'b010, 17'h02000, 32'h0, refMem[17'h02000 >> 2],
                       4'h0, 4, 0, 5), 1'b0, 1'b1, "retry");
        runAndCheck(mk(1'b1, 1'b0, 3'b010, 17'h00040, 32'h0, refMem[17'h00040 >> 2],
                       4'h0, 4, 0, 5), 1'b0, 1'b1, "postrst");

        for (int i = 0; i < 64; i++) cachedLine[i] = -1;
        cachedLine[0] = 32'h2000 >> 4;
        cachedLine[4] = 32'h40 >> 4;

        for (int n = 0; n < 400; n++) begin
            isSt   = ($urandom_range(0, 2) == 0);
            v.addr = 17'(($urandom_range(0, 3) << 10) | $urandom_range(0, 127));
            ln     = int'(v.addr) / 16;
            ix     = ln % 64;
            sel    = int'($urandom_range(0, 4));
            v.wd   = $urandom;
            v.expStall = 0;
            if (isSt) begin
                v.rd      = 1'b0;
                v.wr      = 1'b1;
                v.sz      = 3'(sel % 3);
                v.expBe   = beOf(v.sz, v.addr);
                v.expData = laneOf(v.sz, v.addr, v.wd);
                v.expRd   = 0;
                v.expWr   = 1;
            end else begin
                v.rd      = 1'b1;
                v.wr      = 1'b0;
                v.sz      = (sel < 3) ? 3'(sel) : 3'(sel + 1);
                v.expBe   = 4'h0;
                v.expData = loadExp(refMem[v.addr[16:2]], v.sz, v.addr);
                v.expRd   = (cachedLine[ix] == ln) ? 0 : 4;
                v.expWr   = 0;
                cachedLine[ix] = ln;
            end
            runAndCheck(v, 1'b1, !isSt && v.expRd == 0, $sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dcache.md
Name: dcache

Overview:
- Direct-mapped, write-through, no-write-allocate data cache between the Memory-stage pipeline register outputs and a slower backing data memory.
- Serves loads and stores issued from the Memory stage and applies byte/half/word sizing with sign or zero extension.
- Raises a stall to the hazard logic while it services a miss or a write-through.

Parameters:
DATA_WIDTH, 32, CPU word width.
ADDR_WIDTH, 17, byte address width of the data space.
LINES, 64, number of cache lines (power of 2).
WORDS_PER_LINE, 4, words per line (power of 2).

Ports:
clk  input  1  clock.
rst  input  1  asynchronous active-low reset.
MemReadM  input  1  load request in the Memory stage.
MemWriteM  input  1  store request in the Memory stage.
SizeCtr  input  3  funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu.
ALUResultM  input  ADDR_WIDTH  byte address.
WriteDataM  input  DATA_WIDTH  store data, right-aligned.
ReadData  output  DATA_WIDTH  sized, extended load data.
Stall  output  1  freezes Fetch to Memory stages while high.
mem_req  output  1  backing-memory request.
mem_we  output  1  1 means write beat, 0 means read beat.
mem_addr  output  ADDR_WIDTH  word-aligned beat address.
mem_wdata  output  DATA_WIDTH  lane-aligned write data.
mem_be  output  4  byte enables for writes.
mem_ready  input  1  beat accepted, and read data valid this cycle.
mem_rdata  input  DATA_WIDTH  read beat data.

Behaviour:
Address split:
- Bits [1:0] are the byte offset.
- The next log2(WORDS_PER_LINE) bits are the word.
- The next log2(LINES) bits are the index.
- The remaining bits are the tag.
- With the defaults the tag is 7 bits wide.

Reset (rst low, asynchronous):
- All valid bits are cleared and the FSM goes to IDLE.
- mem_req, mem_we, mem_addr, mem_wdata, mem_be and Stall are 0.
- ReadData is 0.
- A reset during REFILL or WRITE abandons the beat. No partial line is marked valid.

Lookup and load data:
- Lookup is combinational from the arrays.
- Hit = valid[index] && tag match.
- ReadData is the selected word, shifted by the byte offset and sized per SizeCtr: b/h sign-extend, bu/hu zero-extend, w passes through.
- ReadData is 0 when MemReadM is low.
- Alignment is forced: half ignores addr[0], word ignores addr[1:0].

FSM states: IDLE, REFILL, WRITE.

IDLE transitions:
- Load hit: Stall 0, data returned the same cycle, stay in IDLE.
- Load miss: Stall 1 combinationally. Go to REFILL with beat counter 0 and the line base address latched.
- Store (hit or miss): Stall 1. Go to WRITE with the address, lane-shifted data and byte enables latched.
- On a hit, the cached word is updated with the byte enables at the clock edge of the transition.
- A store miss does not allocate.
- If MemReadM and MemWriteM are both high, the store takes priority.

REFILL:
- mem_req=1, mem_we=0, mem_addr = line base + 4*beat, Stall=1.
- On each mem_ready, mem_rdata is written to word[beat] and beat increments.
- After the last beat, write the tag, set valid and return to IDLE.
- The held request then hits next cycle with Stall 0.
- Total miss latency is WORDS_PER_LINE ready beats plus 1 cycle.

WRITE:
- mem_req=1, mem_we=1, Stall=1, with the latched addr/wdata/be held stable.
- On mem_ready, return to IDLE.
- Stall drops the cycle after mem_ready. The pipeline must not re-present the same store. Hazard logic releases the Memory register on the Stall falling edge.

Backing-memory handshake:
- mem_req and all payload stay stable until mem_ready is sampled high.
- mem_ready is ignored while mem_req is 0.

Byte enables:
- sb: 0001 << off.
- sh: 0011 << (off & 2).
- sw: 1111.

Optional Feature:
Macro: DCACHE_PERF_EN.
- When defined, adds three outputs: hit_count, miss_count and wr_count, each 32 bits and cleared on reset.
- Each counter increments once per completed access (load hit, load miss at refill end, store at mem_ready).
- Counters saturate at 0xFFFFFFFF.
- When the macro is undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then lw at 0x0040 with memory words 0x40..0x4C = 11111111, 22222222, 33333333, 44444444 and mem_ready always 1 -> Stall high for 5 cycles, 4 read beats at 0x40, 0x44, 0x48, 0x4C, then ReadData=0x11111111 with Stall 0.
- lw at 0x0048 immediately after the previous test -> hit, Stall 0, ReadData=0x33333333, no mem_req.
- lb at 0x0043 with word=0x80FF7F01 cached -> ReadData=0xFFFFFF80; the same access as lbu -> 0x00000080; lh at 0x0042 -> 0xFFFF80FF.
- sb 0xAB to 0x0041 on a cached line -> mem_be=0010, mem_wdata lane1=0xAB, Stall held until mem_ready. A subsequent lw at 0x40 returns the word with byte1=0xAB and no refill.
- sw to an uncached address 0x1000 -> one write beat, no refill. lw at 0x1000 then misses and refills.
- Assert rst low mid-REFILL after 2 beats -> mem_req drops immediately, Stall=0. Re-request misses again and fetches all 4 beats.
